// File: rtl/debounce_array_if.sv
// Pin-side bundle for debounce_array: raw inputs in, clean levels and per-channel events out.
// The slave modport is the debouncer; the master modport is whatever drives the raw pins.
interface debounce_array_if #(
    parameter int CHANNELS = 4
);
    logic [CHANNELS-1:0] btn_in;
    logic [CHANNELS-1:0] btn_out;
    logic [CHANNELS-1:0] btn_rise;
    logic [CHANNELS-1:0] btn_fall;
    logic [CHANNELS-1:0] btn_long;

    modport master (output btn_in, input btn_out, btn_rise, btn_fall, btn_long);
    modport slave  (input btn_in, output btn_out, btn_rise, btn_fall, btn_long);
endinterface

// File: rtl/debounce_array.sv
// Multi-channel synchroniser + debouncer with registered rise/fall pulses per channel.
// Long-press detector is built only when DEBOUNCE_LONGPRESS_EN is defined.
module debounce_lane #(
    parameter int DEBOUNCE_TIME = 500_000,
    parameter int LONG_TIME     = 50_000_000
) (
    input  logic clk,
    input  logic reset_n,
    input  logic raw,
    output logic level,
    output logic rise,
    output logic fall,
    output logic long_press
);
    localparam int DW = (DEBOUNCE_TIME > 1) ? $clog2(DEBOUNCE_TIME) : 1;
    localparam logic [DW-1:0] DB_MAX = DW'(DEBOUNCE_TIME - 1);

    logic          sync0, sync1;
    logic [DW-1:0] db_cnt;
    logic          accept;
    logic          fall_now;

    // Saturating at DB_MAX means the mismatch has persisted long enough.
    assign accept   = (sync1 != level) && (db_cnt == DB_MAX);
    assign fall_now = accept && level;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync0  <= 1'b0;
            sync1  <= 1'b0;
            db_cnt <= '0;
            level  <= 1'b0;
            rise   <= 1'b0;
            fall   <= 1'b0;
        end else begin
            sync0 <= raw;
            sync1 <= sync0;
            if ((sync1 == level) || accept) db_cnt <= '0;
            else                            db_cnt <= db_cnt + 1'b1;
            if (accept) level <= sync1;
            rise <= accept && !level;
            fall <= fall_now;
        end
    end

`ifdef DEBOUNCE_LONGPRESS_EN
    typedef enum logic {ARMED, FIRED} lp_state_t;

    localparam int HW = (LONG_TIME > 1) ? $clog2(LONG_TIME) : 1;
    localparam logic [HW-1:0] HOLD_MAX = HW'(LONG_TIME - 1);

    lp_state_t     state, state_d;
    logic [HW-1:0] hold, hold_d;
    logic          long_d;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= ARMED;
            hold       <= '0;
            long_press <= 1'b0;
        end else begin
            state      <= state_d;
            hold       <= hold_d;
            long_press <= long_d;
        end
    end

    // The releasing edge itself re-arms, so a fall never coincides with a long pulse.
    always_comb begin
        state_d = state;
        hold_d  = hold;
        long_d  = 1'b0;
        if (!level || fall_now) begin
            state_d = ARMED;
            hold_d  = '0;
        end else if (state == ARMED) begin
            if (hold == HOLD_MAX) begin
                long_d  = 1'b1;
                state_d = FIRED;
            end else begin
                hold_d = hold + 1'b1;
            end
        end
    end
`else
    // Detector compiled out: LONG_TIME has no effect and the output is constant low.
    assign long_press = 1'b0 & (LONG_TIME != 0);
`endif
endmodule

module debounce_array #(
    parameter int CHANNELS      = 4,
    parameter int DEBOUNCE_TIME = 500_000,
    parameter int LONG_TIME     = 50_000_000
) (
    input  logic             clk,
    input  logic             reset_n,
    debounce_array_if.slave  bus
);
    for (genvar i = 0; i < CHANNELS; i++) begin : g_lane
        debounce_lane #(
            .DEBOUNCE_TIME (DEBOUNCE_TIME),
            .LONG_TIME     (LONG_TIME)
        ) u_lane (
            .clk        (clk),
            .reset_n    (reset_n),
            .raw        (bus.btn_in[i]),
            .level      (bus.btn_out[i]),
            .rise       (bus.btn_rise[i]),
            .fall       (bus.btn_fall[i]),
            .long_press (bus.btn_long[i])
        );
    end
endmodule
